// File: rtl/hweval_mont_driver_if.sv
// Start/done handshake and operand bus between the evaluation driver and one Montgomery multiplier core.
interface hweval_mont_driver_if #(
    parameter int WIDTH = 1024
);
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (output mm_start, mm_a, mm_b, mm_m, input mm_result, mm_done);
    modport slave  (input mm_start, mm_a, mm_b, mm_m, output mm_result, mm_done);
endinterface

// File: rtl/hweval_mont_driver.sv
// Drives N_ITER chained multiplications through an external core, folding results into a rotating XOR signature.
// Per-iteration turnaround of 2 cycles around the core latency; hung core trapped in ERROR after TIMEOUT cycles.
module hweval_mont_driver #(
    parameter int               WIDTH   = 1024,
    parameter int               N_ITER  = 16,
    parameter int               TIMEOUT = 4096,
    parameter logic [WIDTH-1:0] SEED_A  = 1,
    parameter logic [WIDTH-1:0] SEED_B  = 1,
    parameter logic [WIDTH-1:0] MODULUS = 0,
    parameter logic [WIDTH-1:0] EXP_SIG = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 run,
    hweval_mont_driver_if.master mm,
    output logic                 busy,
    output logic                 finished,
    output logic                 timeout_err,
    output logic [31:0]          iter_count,
    output logic [31:0]          cycles_last,
    output logic [31:0]          cycles_max,
    output logic [WIDTH-1:0]     signature,
    output logic                 data_ok
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]       state;
    logic             start_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [31:0]      cnt;
    logic [31:0]      iter_next;
    logic [WIDTH-1:0] sig_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign iter_next = sat_inc(iter_count);
    assign sig_next  = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ res;

    assign mm.mm_start = start_q;
    assign mm.mm_a     = op_a;
    assign mm.mm_b     = op_b;
    assign mm.mm_m     = MODULUS;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            op_a        <= SEED_A;
            op_b        <= SEED_B;
            res         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
            iter_count  <= '0;
            cycles_last <= '0;
            cycles_max  <= '0;
            signature   <= '0;
            data_ok     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        op_a       <= SEED_A;
                        op_b       <= SEED_B;
                        signature  <= '0;
                        iter_count <= '0;
                        cycles_max <= '0;
                        cnt        <= '0;
                        finished   <= 1'b0;
                        data_ok    <= 1'b0;
                        busy       <= 1'b1;
                        start_q    <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= sat_inc(cnt);
                    // A completion on the last allowed cycle still counts as success.
                    if (mm.mm_done) begin
                        res         <= mm.mm_result;
                        cycles_last <= sat_inc(cnt);
                        state       <= S_UPDATE;
                    end else if (cnt == 32'(TIMEOUT - 1)) begin
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_ERROR;
                    end
                end
                S_UPDATE: begin
                    op_a       <= op_b ^ res;
                    op_b       <= res;
                    signature  <= sig_next;
                    iter_count <= iter_next;
                    if (cycles_last > cycles_max) cycles_max <= cycles_last;
                    if (iter_next == 32'(N_ITER)) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        data_ok  <= (sig_next == EXP_SIG);
                        state    <= S_DONE;
                    end else begin
                        start_q <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                end
                S_ERROR: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hweval_mont_driver.sv
// Three drivers on 8-bit mock cores (result = a+b): golden signature, wrong signature, and a core that never completes.
module tb_hweval_mont_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn     [3];
    logic       run_i    [3];
    logic       ob_start [3];
    logic [7:0] ob_a     [3];
    logic [7:0] ob_b     [3];
    logic [7:0] ob_m     [3];
    logic       busy_o   [3];
    logic       fin_o    [3];
    logic       terr_o   [3];
    logic       ok_o     [3];
    logic [31:0] itc     [3];
    logic [31:0] cl_o    [3];
    logic [31:0] cm_o    [3];
    logic [7:0] sig_o    [3];
    int         lat_tab  [3][4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  sig;
        logic [31:0] it;
        logic [31:0] cl;
        logic [31:0] cm;
        logic        ok;
    } snap_t;

    snap_t       snap_q0[$];
    snap_t       snap_q1[$];
    logic [15:0] op_q[$];
    int          start_cnt [3];
    logic        fin_prev  [3];

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam logic [7:0] EXP = (i == 1) ? 8'h0A : 8'h09;
        localparam int         TO  = (i == 2) ? 16 : 64;
        localparam bit         NEVER = (i == 2);

        hweval_mont_driver_if #(.WIDTH(8)) bus ();

        hweval_mont_driver #(
            .WIDTH(8), .N_ITER(4), .TIMEOUT(TO),
            .SEED_A(8'h01), .SEED_B(8'h01), .MODULUS(8'hF1), .EXP_SIG(EXP)
        ) dut (
            .clk(clk), .resetn(rstn[i]), .run(run_i[i]), .mm(bus.master),
            .busy(busy_o[i]), .finished(fin_o[i]), .timeout_err(terr_o[i]),
            .iter_count(itc[i]), .cycles_last(cl_o[i]), .cycles_max(cm_o[i]),
            .signature(sig_o[i]), .data_ok(ok_o[i])
        );

        logic mk_done;
        logic pend;
        int   wc;
        int   lat;
        assign lat = lat_tab[i][itc[i][1:0]];
        assign bus.mm_result = bus.mm_a + bus.mm_b;
        assign bus.mm_done   = mk_done;
        assign ob_start[i]   = bus.mm_start;
        assign ob_a[i]       = bus.mm_a;
        assign ob_b[i]       = bus.mm_b;
        assign ob_m[i]       = bus.mm_m;

        // Mock core: done is raised in WAIT cycle number 'lat' after each start pulse.
        always @(posedge clk) begin
            if (!rstn[i]) begin
                pend <= 1'b0; mk_done <= 1'b0; wc <= 0;
            end else if (mk_done) begin
                pend <= 1'b0; mk_done <= 1'b0;
            end else if (bus.mm_start) begin
                pend <= !NEVER; wc <= 1; mk_done <= !NEVER && (lat == 1);
            end else if (pend) begin
                wc <= wc + 1; mk_done <= (wc + 1 == lat);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_snap(input int i, input snap_t e);
        chk($sformatf("d%0d_mm_a", i), 32'(ob_a[i]), 32'(e.a));
        chk($sformatf("d%0d_mm_b", i), 32'(ob_b[i]), 32'(e.b));
        chk($sformatf("d%0d_signature", i), 32'(sig_o[i]), 32'(e.sig));
        chk($sformatf("d%0d_iter_count", i), itc[i], e.it);
        chk($sformatf("d%0d_cycles_last", i), cl_o[i], e.cl);
        chk($sformatf("d%0d_cycles_max", i), cm_o[i], e.cm);
        chk($sformatf("d%0d_data_ok", i), 32'(ok_o[i]), 32'(e.ok));
        chk($sformatf("d%0d_busy_done", i), 32'(busy_o[i]), 32'd0);
    endtask

    // Monitor: final snapshots on each rising finished, operand pairs on each start of driver 0.
    initial begin
        for (int i = 0; i < 3; i++) begin start_cnt[i] = 0; fin_prev[i] = 1'b0; end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (ob_start[i]) start_cnt[i] <= start_cnt[i] + 1;
        if (fin_o[0] && !fin_prev[0]) begin
            chk("d0_snap_expected", 32'(snap_q0.size() > 0), 32'd1);
            if (snap_q0.size() > 0) cmp_snap(0, snap_q0.pop_front());
        end
        if (fin_o[1] && !fin_prev[1]) begin
            chk("d1_snap_expected", 32'(snap_q1.size() > 0), 32'd1);
            if (snap_q1.size() > 0) cmp_snap(1, snap_q1.pop_front());
        end
        if (ob_start[0]) begin
            chk("d0_start_expected", 32'(op_q.size() > 0), 32'd1);
            if (op_q.size() > 0) begin
                logic [15:0] e;
                e = op_q.pop_front();
                chk("d0_start_a", 32'(ob_a[0]), 32'(e[15:8]));
                chk("d0_start_b", 32'(ob_b[0]), 32'(e[7:0]));
            end
        end
        for (int i = 0; i < 3; i++) fin_prev[i] <= fin_o[i];
    end

    task automatic push_chain();
        op_q.push_back(16'h0101); op_q.push_back(16'h0302);
        op_q.push_back(16'h0705); op_q.push_back(16'h090C);
    endtask

    task automatic push_snap0(input int cl, input int cm);
        snap_q0.push_back('{a: 8'h19, b: 8'h15, sig: 8'h09, it: 4, cl: cl, cm: cm, ok: 1'b1});
    endtask

    task automatic set_lat(input int i, input int l0, input int l1, input int l2, input int l3);
        lat_tab[i][0] = l0; lat_tab[i][1] = l1; lat_tab[i][2] = l2; lat_tab[i][3] = l3;
    endtask

    task automatic pulse_run(input int i);
        @(posedge clk); #1 run_i[i] = 1'b1;
        @(posedge clk); #1 run_i[i] = 1'b0;
    endtask

    task automatic wait_fin(input int i, input string nm);
        int n = 0;
        while (!fin_o[i] && n < 600) begin @(negedge clk); n++; end
        chk({nm, "_finished"}, 32'(fin_o[i]), 32'd1);
    endtask

    task automatic check_reset(input int i);
        chk($sformatf("rst%0d_mm_start", i), 32'(ob_start[i]), 32'd0);
        chk($sformatf("rst%0d_busy", i), 32'(busy_o[i]), 32'd0);
        chk($sformatf("rst%0d_finished", i), 32'(fin_o[i]), 32'd0);
        chk($sformatf("rst%0d_timeout_err", i), 32'(terr_o[i]), 32'd0);
        chk($sformatf("rst%0d_data_ok", i), 32'(ok_o[i]), 32'd0);
        chk($sformatf("rst%0d_iter_count", i), itc[i], 32'd0);
        chk($sformatf("rst%0d_cycles_last", i), cl_o[i], 32'd0);
        chk($sformatf("rst%0d_cycles_max", i), cm_o[i], 32'd0);
        chk($sformatf("rst%0d_signature", i), 32'(sig_o[i]), 32'd0);
        chk($sformatf("rst%0d_mm_a", i), 32'(ob_a[i]), 32'd1);
        chk($sformatf("rst%0d_mm_b", i), 32'(ob_b[i]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int base;
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; run_i[i] = 1'b0; set_lat(i, 3, 3, 3, 3);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset(i);
        chk("mm_m_const", 32'(ob_m[0]), 32'hF1);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

        // Chained run on the golden and wrong-signature drivers together.
        push_chain(); push_snap0(3, 3);
        snap_q1.push_back('{a: 8'h19, b: 8'h15, sig: 8'h09, it: 4, cl: 3, cm: 3, ok: 1'b0});
        @(posedge clk); #1 run_i[0] = 1'b1; run_i[1] = 1'b1;
        @(posedge clk); #1 run_i[0] = 1'b0; run_i[1] = 1'b0;
        chk("run_busy_next", 32'(busy_o[0]), 32'd1);
        chk("run_start_next", 32'(ob_start[0]), 32'd1);
        wait_fin(0, "chain");
        wait_fin(1, "badsig");

        // Done on the final allowed WAIT cycle must win over the timeout.
        set_lat(0, 64, 3, 3, 3);
        push_chain(); push_snap0(3, 64);
        pulse_run(0);
        wait_fin(0, "edge_timeout");
        chk("edge_no_err", 32'(terr_o[0]), 32'd0);

        set_lat(0, 5, 2, 9, 1);
        push_chain(); push_snap0(1, 9);
        pulse_run(0);
        wait_fin(0, "varlat");

        // run held high: one start per iteration, restart only from DONE.
        set_lat(0, 3, 3, 3, 3);
        push_chain(); push_snap0(3, 3);
        push_chain(); push_snap0(3, 3);
        @(posedge clk); #1 run_i[0] = 1'b1;
        @(posedge clk); #1;
        wait_fin(0, "held1");
        @(posedge clk); #1;
        chk("held_restart_iter", itc[0], 32'd0);
        chk("held_restart_start", 32'(ob_start[0]), 32'd1);
        run_i[0] = 1'b0;
        wait_fin(0, "held2");

        // Reset during the second WAIT, then a clean run.
        op_q.push_back(16'h0101); op_q.push_back(16'h0302);
        base = start_cnt[0];
        pulse_run(0);
        n = 0;
        while (start_cnt[0] < base + 2 && n < 200) begin @(negedge clk); n++; end
        chk("midrst_second_start", 32'(start_cnt[0] - base), 32'd2);
        @(posedge clk); #1 rstn[0] = 1'b0;
        @(posedge clk); #1;
        check_reset(0);
        rstn[0] = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_start", 32'(ob_start[0]), 32'd0);
        push_chain(); push_snap0(3, 3);
        pulse_run(0);
        wait_fin(0, "after_rst");

        // Hung core on driver 2.
        pulse_run(2);
        n = 0;
        while (!ob_start[2] && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (!terr_o[2] && n < 100) begin @(negedge clk); n++; end
        chk("to_err_set", 32'(terr_o[2]), 32'd1);
        chk("to_delay", 32'(cyc - t0), 32'd17);
        chk("to_busy", 32'(busy_o[2]), 32'd0);
        pulse_run(2);
        repeat (20) @(posedge clk);
        #1;
        chk("to_run_ignored", 32'(start_cnt[2]), 32'd1);
        chk("to_err_held", 32'(terr_o[2]), 32'd1);
        rstn[2] = 1'b0;
        @(posedge clk); #1 rstn[2] = 1'b1;
        chk("to_err_cleared", 32'(terr_o[2]), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("ops_left", 32'(op_q.size()), 32'd0);
        chk("snaps_left", 32'(snap_q0.size() + snap_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hweval_mont_driver.md
# hweval_mont_driver

Parametrised hardware-evaluation driver for a Montgomery multiplier core. It drives N_ITER chained multiplications through a start/done handshake. Between iterations it feeds each result back into the operands, folds every result into a rotating XOR signature, measures per-operation latency and guards against a hung core with a timeout. It sits between board-level control (run, status LEDs) and one externally instantiated multiplier. The signature and compare output stop synthesis from pruning the datapath.

## Interface
Parameters:
- WIDTH, 1024: operand/result width.
- N_ITER, 16: multiplications per run (>=1).
- TIMEOUT, 4096: max WAIT cycles per operation (>=2).
- SEED_A, 1: initial a (WIDTH bits).
- SEED_B, 1: initial b (WIDTH bits).
- MODULUS, 0: modulus driven on mm_m (WIDTH bits).
- EXP_SIG, 0: golden signature (WIDTH bits).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- run  in  1  start a run; sampled only in IDLE or DONE.
- mm_start  out  1  one-cycle start pulse to the core.
- mm_a, mm_b, mm_m  out  WIDTH  operands, stable from LAUNCH through WAIT.
- mm_result  in  WIDTH  core result, valid when mm_done=1.
- mm_done  in  1  core completion, sampled only in WAIT.
- busy  out  1  high in LAUNCH/WAIT/UPDATE.
- finished  out  1  high in DONE.
- timeout_err  out  1  high in ERROR.
- iter_count  out  32  completed multiplications in the current run.
- cycles_last  out  32  latency of the most recent operation.
- cycles_max  out  32  max latency in the current run.
- signature  out  WIDTH  running result signature.
- data_ok  out  1  finished & (signature == EXP_SIG).

## Operation
- States: IDLE, LAUNCH, WAIT, UPDATE, DONE, ERROR.
- IDLE/DONE with run=1:
  - Load a=SEED_A, b=SEED_B.
  - Clear signature, iter_count, cycles_max and the cycle counter.
  - Go to LAUNCH.
- LAUNCH (1 cycle): mm_start=1; counter cleared; go to WAIT.
- WAIT:
  - counter increments each cycle.
  - If mm_done=1: capture mm_result, set cycles_last = counter+1, go to UPDATE.
  - Otherwise, if counter == TIMEOUT-1: go to ERROR.
- UPDATE (1 cycle):
  - a <= b ^ r; b <= r.
  - signature <= rotl1(signature) ^ r (rotate left by 1 over WIDTH bits).
  - iter_count += 1; cycles_max = max(cycles_max, cycles_last).
  - If the new iter_count == N_ITER, go to DONE; else go to LAUNCH.
- DONE: hold all registers. run restarts a fresh run.
- ERROR: hold all registers; run is ignored. Only resetn exits.
- Ignored inputs:
  - run in LAUNCH/WAIT/UPDATE.
  - mm_done outside WAIT.
- mm_m = MODULUS constantly.
- Counters saturate at 2^32-1; no wrap.

## Timing
- All outputs registered. Reset values:
  - mm_start=0, busy=0, finished=0, timeout_err=0, data_ok=0.
  - iter_count=0, cycles_last=0, cycles_max=0, signature=0.
  - mm_a=SEED_A, mm_b=SEED_B; state IDLE.
- run sampled at edge t: mm_start high during cycle t+1 only; busy high from t+1.
- mm_done sampled at edge t (WAIT): UPDATE at t+1, mm_start high at t+2. Turnaround is 2 cycles per iteration.
- mm_done in the first WAIT cycle gives cycles_last=1.
- mm_done together with counter==TIMEOUT-1: done wins; no error.
- Last UPDATE at edge t: finished and data_ok valid from t+1; busy low from t+1.
- resetn low mid-run:
  - Reset values apply at the next edge; any pending mm_done is discarded.
  - mm_start is never high in the cycle after reset.

## Test plan
Bench uses a mock core with WIDTH=8: mm_result = (a+b) mod 256, mm_done asserted in the 3rd WAIT cycle.
- Chained run, N_ITER=4, seeds 1/1, EXP_SIG=8'h09, pulse run:
  - results 0x02, 0x05, 0x0C, 0x15.
  - final mm_a=0x19, mm_b=0x15, signature=0x09.
  - iter_count=4, cycles_last=cycles_max=3, finished=1, data_ok=1.
- Same run with EXP_SIG=8'h0A -> finished=1, data_ok=0.
- Mock never asserts mm_done, TIMEOUT=16:
  - timeout_err=1 exactly 17 cycles after mm_start; busy=0.
  - a later run is ignored until resetn.
- Variable latency, mock latencies 5,2,9,1 -> cycles_last=1, cycles_max=9 at finish.
- run held high throughout -> exactly one mm_start per iteration, no mid-run restart. After DONE, run restarts with iter_count cleared.
- resetn low during the 2nd WAIT -> all outputs at reset values next cycle. A following run completes normally with signature=0x09.
